// File: rtl/popcount_pkg.sv
// Shared constants and width helpers for the popcount block and its leaf counter.
`timescale 1ns/1ps
package popcount_pkg;

   localparam int LEAF_WIDTH = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   // Bits needed to hold a count ranging 0..in_width inclusive.
   function automatic int count_width(input int in_width);
      return clog2(in_width + 1);
   endfunction

endpackage

// File: rtl/popcount_leaf.sv
// Counts the set bits of one 4-bit nibble; first level of the popcount adder tree.
`timescale 1ns/1ps
module popcount_leaf
   import popcount_pkg::*;
(
   input  logic [LEAF_WIDTH-1:0] bits_in,
   output logic [2:0]            count
);

   always_comb begin
      count = 3'd0;
      case (bits_in)
         4'h0:                                 count = 3'd0;
         4'h1, 4'h2, 4'h4, 4'h8:               count = 3'd1;
         4'h3, 4'h5, 4'h6, 4'h9, 4'hA, 4'hC:   count = 3'd2;
         4'h7, 4'hB, 4'hD, 4'hE:               count = 3'd3;
         4'hF:                                 count = 3'd4;
         default:                              count = 3'd0;
      endcase
   end

endmodule

// File: rtl/popcount.sv
// Population count: combinational io_out from a nibble-leaf adder tree, plus a
// registered copy io_out_q for consumers that need a flop boundary.
`timescale 1ns/1ps
module popcount
   import popcount_pkg::*;
#(
   parameter int DATA_IN_WIDTH  = 16,
   parameter int DATA_OUT_WIDTH = 5
)(
   input  logic                      clock,
   input  logic                      reset,
   input  logic [DATA_IN_WIDTH-1:0]  io_in,
   output logic [DATA_OUT_WIDTH-1:0] io_out,
   output logic [DATA_OUT_WIDTH-1:0] io_out_q
);

   localparam int N_LEAF = (DATA_IN_WIDTH + LEAF_WIDTH - 1) / LEAF_WIDTH;
   localparam int LEVELS = clog2(N_LEAF);
   localparam int N_SLOT = 1 << LEVELS;
   localparam int PAD_W  = N_LEAF * LEAF_WIDTH;

   if (DATA_IN_WIDTH < 1 || DATA_IN_WIDTH > 64) begin : g_bad_in_width
      $error("popcount: DATA_IN_WIDTH must lie in 1..64");
   end
   if (DATA_OUT_WIDTH < count_width(DATA_IN_WIDTH)) begin : g_bad_out_width
      $error("popcount: DATA_OUT_WIDTH too narrow for DATA_IN_WIDTH");
   end

   // Zero padding keeps the last partial nibble free of X and adds nothing to the count.
   logic [PAD_W-1:0] padded;
   assign padded = PAD_W'(io_in);

   // Level lv holds N_SLOT>>lv partial sums, each 3+lv bits wide; empty slots are zero.
   genvar lv, j;
   for (lv = 0; lv <= LEVELS; lv++) begin : g_lvl
      localparam int NODES = N_SLOT >> lv;
      logic [2+lv:0] sum [NODES];
      for (j = 0; j < NODES; j++) begin : g_node
         if (lv == 0) begin : g_leaf
            if (j < N_LEAF) begin : g_used
               popcount_leaf u_leaf (
                  .bits_in (padded[j*LEAF_WIDTH +: LEAF_WIDTH]),
                  .count   (sum[j])
               );
            end else begin : g_empty
               assign sum[j] = '0;
            end
         end else begin : g_add
            assign sum[j] = {1'b0, g_lvl[lv-1].sum[2*j]} + {1'b0, g_lvl[lv-1].sum[2*j+1]};
         end
      end
   end

   assign io_out = DATA_OUT_WIDTH'(g_lvl[LEVELS].sum[0]);

   logic [DATA_OUT_WIDTH-1:0] io_out_d;

   always_comb begin
      io_out_d = io_out;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) io_out_q <= '0;
      else        io_out_q <= io_out_d;
   end

endmodule

// File: tb/tb_popcount.sv
// Scoreboard bench for popcount: stimulus queues expected counts, a monitor
// pops and compares them against a 16-bit and a 7-bit instance.
`timescale 1ns/1ps
module tb_popcount;

   logic        clock;
   logic        reset;
   logic [15:0] io_in;
   logic [4:0]  io_out;
   logic [4:0]  io_out_q;
   logic [6:0]  io_in7;
   logic [2:0]  io_out7;
   logic [2:0]  io_out_q7;

   popcount #(.DATA_IN_WIDTH(16), .DATA_OUT_WIDTH(5)) u_dut (
      .clock    (clock),
      .reset    (reset),
      .io_in    (io_in),
      .io_out   (io_out),
      .io_out_q (io_out_q)
   );

   popcount #(.DATA_IN_WIDTH(7), .DATA_OUT_WIDTH(3)) u_dut7 (
      .clock    (clock),
      .reset    (reset),
      .io_in    (io_in7),
      .io_out   (io_out7),
      .io_out_q (io_out_q7)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      string name;
      int    dut;
      bit    chk_out;
      int    exp_out;
      bit    chk_q;
      int    exp_q;
   } sb_entry_t;

   sb_entry_t sb[$];
   event      sample_ev;
   int        tests;
   int        failed;
   bit        done;

   function automatic int pc(input int v, input int w);
      int n;
      n = 0;
      for (int i = 0; i < w; i++) if (v[i]) n++;
      return n;
   endfunction

   task automatic check(input string name, input int dut, input bit co, input int eo,
                        input bit cq, input int eq);
      sb_entry_t e;
      #0.01;
      e.name = name; e.dut = dut; e.chk_out = co; e.exp_out = eo; e.chk_q = cq; e.exp_q = eq;
      sb.push_back(e);
      -> sample_ev;
      #0.01;
   endtask

   initial begin
      sb_entry_t e;
      int act_out, act_q;
      forever begin
         @(sample_ev);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.dut == 0) begin
               act_out = int'(io_out);  act_q = int'(io_out_q);
            end else begin
               act_out = int'(io_out7); act_q = int'(io_out_q7);
            end
            if (e.chk_out) begin
               tests++;
               if (act_out != e.exp_out) begin
                  failed++;
                  $display("FAIL %s: io_out=%0d expected %0d", e.name, act_out, e.exp_out);
               end
            end
            if (e.chk_q) begin
               tests++;
               if (act_q != e.exp_q) begin
                  failed++;
                  $display("FAIL %s: io_out_q=%0d expected %0d", e.name, act_q, e.exp_q);
               end
            end
         end
      end
   end

   initial begin
      #2ms;
      if (!done) begin
         $display("FAIL watchdog: run not finished, tests=%0d expected completion", tests);
         $fatal(1, "watchdog expired");
      end
   end

   logic [15:0] dir_in  [8] = '{16'h0000, 16'h0001, 16'h00FF, 16'hAAAA,
                                16'hFFFF, 16'h0F0F, 16'h8001, 16'h1234};
   int          dir_exp [8] = '{0, 1, 8, 8, 16, 8, 2, 5};

   initial begin
      tests = 0; failed = 0; done = 1'b0;
      reset = 1'b0; io_in = 16'h0000; io_in7 = 7'h00;
      #1;
      check("reset_state", 0, 1, 0, 1, 0);
      check("reset_state7", 1, 1, 0, 1, 0);

      for (int i = 0; i < 8; i++) begin
         @(negedge clock);
         io_in = dir_in[i];
         check("directed", 0, 1, dir_exp[i], 1, 0);
      end

      for (int v = 0; v < 65536; v++) begin
         @(negedge clock);
         io_in = 16'(v);
         check("sweep16", 0, 1, pc(v, 16), 1, 0);
      end

      for (int i = 0; i < 16; i++) begin
         @(negedge clock);
         io_in = 16'h0001 << i;
         check("walk_one", 0, 1, 1, 0, 0);
         io_in = ~(16'h0001 << i);
         check("walk_zero", 0, 1, 15, 0, 0);
      end

      for (int v = 0; v < 128; v++) begin
         @(negedge clock);
         io_in7 = 7'(v);
         check("sweep7", 1, 1, pc(v, 7), 1, 0);
      end
      check("w7_all_ones", 1, 1, 7, 0, 0);

      @(negedge clock);
      reset = 1'b1;
      io_in = 16'h0F0F;
      check("release_comb", 0, 1, 8, 1, 0);
      @(posedge clock); #1;
      check("release_reg", 0, 1, 8, 1, 8);
      check("release_reg7", 1, 1, 7, 1, 7);

      @(negedge clock);
      io_in = 16'hFFFF;
      @(posedge clock); #1;
      check("full_reg", 0, 1, 16, 1, 16);
      #2;
      reset = 1'b0;
      check("async_reset", 0, 1, 16, 1, 0);

      @(negedge clock);
      reset = 1'b1;
      @(posedge clock); #1;
      check("first_edge", 0, 1, 16, 1, 16);
      io_in = 16'h0000;
      check("track_0", 0, 1, 0, 1, 16);
      @(posedge clock); #1;
      io_in = 16'hFFFF;
      check("track_16", 0, 1, 16, 1, 0);
      @(posedge clock); #1;
      io_in = 16'h8001;
      check("track_2", 0, 1, 2, 1, 16);
      @(posedge clock); #1;
      check("lag_2", 0, 1, 2, 1, 2);

      #10;
      done = 1'b1;
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
